// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one asynchronous SRAM between
// a read-only fetch port and a read/write data port.
module mem_arbiter #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        if_req,
    input  logic [17:0] if_addr,
    output logic [15:0] if_rdata,
    output logic        if_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [17:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic [15:0] d_rdata,
    output logic        d_ack,
    output logic        ramEN,
    output logic        ramOE,
    output logic        ramWE,
    output logic [17:0] ramAddr,
    inout  wire  [15:0] ramData
);
    typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, ACK} state_t;
    localparam logic [2:0] WAIT = 3'(WAIT_CYCLES);

    state_t      state;
    logic        last_d;
    logic        cur_d;
    logic        drive;
    logic [2:0]  cnt;
    logic [15:0] wdata;
    logic        sel_d;

    // on a conflict the port that was not granted last wins
    assign sel_d   = d_req && (!if_req || !last_d);
    assign ramData = drive ? wdata : 'z;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            ramEN    <= 1'b1;
            ramOE    <= 1'b1;
            ramWE    <= 1'b1;
            ramAddr  <= '0;
            drive    <= 1'b0;
            wdata    <= '0;
            if_rdata <= '0;
            d_rdata  <= '0;
            if_ack   <= 1'b0;
            d_ack    <= 1'b0;
            last_d   <= 1'b0;
            cur_d    <= 1'b0;
            cnt      <= '0;
        end else begin
            // counter reloads on every entry; only RD and WR_PULSE count down
            cnt <= WAIT;
            case (state)
                IDLE: if (if_req || d_req) begin
                    cur_d   <= sel_d;
                    last_d  <= sel_d;
                    ramAddr <= sel_d ? d_addr : if_addr;
                    wdata   <= d_wdata;
                    ramEN   <= 1'b0;
                    if (sel_d && d_we) begin
                        state <= WR_SETUP;
                        drive <= 1'b1;
                    end else begin
                        state <= RD;
                        ramOE <= 1'b0;
                    end
                end
                RD: if (cnt == 3'd0) begin
                    state <= ACK;
                    ramEN <= 1'b1;
                    ramOE <= 1'b1;
                    if (cur_d) begin
                        d_rdata <= ramData;
                        d_ack   <= 1'b1;
                    end else begin
                        if_rdata <= ramData;
                        if_ack   <= 1'b1;
                    end
                end else cnt <= cnt - 3'd1;
                WR_SETUP: begin
                    state <= WR_PULSE;
                    ramWE <= 1'b0;
                end
                WR_PULSE: if (cnt == 3'd0) begin
                    state <= WR_HOLD;
                    ramWE <= 1'b1;
                end else cnt <= cnt - 3'd1;
                WR_HOLD: begin
                    state <= ACK;
                    drive <= 1'b0;
                    ramEN <= 1'b1;
                    d_ack <= 1'b1;
                end
                ACK: begin
                    state  <= IDLE;
                    if_ack <= 1'b0;
                    d_ack  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized bench for mem_arbiter checked against a
// transaction-level model (latencies, strobe counts, round-robin, memory image).
module tb_mem_arbiter;
    localparam int W = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [17:0] if_addr = '0, d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic [15:0] if_rdata, d_rdata;
    logic        if_ack, d_ack, ram_en, ram_oe, ram_we;
    logic [17:0] ram_addr;
    wire  [15:0] ram_data;

    logic        q_req = 1'b0;
    logic [17:0] q_addr = '0;
    logic [15:0] q_rdata, q_drdata;
    logic        q_ack, q_dack, q_en, q_oe, q_we;
    logic [17:0] q_raddr;
    wire  [15:0] q_data;

    int          n_cmp = 0, n_bad = 0;
    logic [15:0] mem [0:262143];
    logic [15:0] ref_mem [logic [17:0]];
    logic [15:0] exp_if = '0, exp_d = '0;
    bit          last_d = 1'b0;

    mem_arbiter u_dut (
        .CLK(clk), .RST(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .ramEN(ram_en), .ramOE(ram_oe), .ramWE(ram_we), .ramAddr(ram_addr), .ramData(ram_data)
    );

    mem_arbiter #(.WAIT_CYCLES(0)) u_fast (
        .CLK(clk), .RST(rst_n),
        .if_req(q_req), .if_addr(q_addr), .if_rdata(q_rdata), .if_ack(q_ack),
        .d_req(1'b0), .d_we(1'b0), .d_addr(18'h0), .d_wdata(16'h0),
        .d_rdata(q_drdata), .d_ack(q_dack),
        .ramEN(q_en), .ramOE(q_oe), .ramWE(q_we), .ramAddr(q_raddr), .ramData(q_data)
    );

    // an undriven bus floats to all-ones, which write data never uses
    pullup (ram_data);
    pullup (q_data);
    assign ram_data = (!ram_en && !ram_oe) ? mem[ram_addr] : 'z;
    assign q_data   = (!q_en && !q_oe) ? (q_raddr[15:0] ^ 16'h1357) : 'z;
    always @(posedge ram_we) if (!ram_en) mem[ram_addr] <= ram_data;

    function automatic logic [15:0] init_val(input logic [17:0] a);
        return a[15:0] ^ 16'hC3A5 ^ {14'h0, a[17:16]};
    endfunction

    function automatic logic [15:0] ref_rd(input logic [17:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) check("oe_we_never_both_low", 32'((ram_oe | ram_we) & (q_oe | q_we)), 1);

    // Follows one granted transaction from the grant edge (next posedge) to one cycle past its ack.
    task automatic observe(input bit p, input bit we, input logic [17:0] a, input logic [15:0] wd, input bit hold);
        int lat, ack_k, oe_n, we_n, dr_n, bad, drop_k;
        bit drv;
        lat = we ? W + 3 : W + 1;
        ack_k = -1; oe_n = 0; we_n = 0; dr_n = 0; bad = 0;
        drop_k = hold ? 99 : int'($urandom_range(0, lat));
        for (int k = 0; k <= lat + 3 && ack_k < 0; k++) begin
            @(posedge clk); @(negedge clk);
            drv = ram_oe && ram_data != 16'hFFFF;
            oe_n += int'(!ram_oe);
            we_n += int'(!ram_we);
            dr_n += int'(drv);
            if ((!ram_en && ram_addr != a) || (drv && ram_data != wd) || (p ? if_ack : d_ack)) bad++;
            if (p ? d_ack : if_ack) ack_k = k;
            if (k == 0 && !hold) begin
                if (p) begin
                    d_addr = 18'($urandom); d_wdata = 16'($urandom); d_we = 1'($urandom);
                end else if_addr = 18'($urandom);
            end
            if (k >= drop_k) begin
                if (p) d_req = 1'b0; else if_req = 1'b0;
            end
        end
        check("ack_latency", 32'(ack_k), 32'(lat));
        check("oe_low_cycles", 32'(oe_n), we ? 0 : W + 1);
        check("we_low_cycles", 32'(we_n), we ? W + 1 : 0);
        check("driven_cycles", 32'(dr_n), we ? W + 3 : 0);
        check("addr_data_ack_errors", 32'(bad), 0);
        if (we) begin
            ref_mem[a] = wd;
            check("sram_written", 32'(mem[a]), 32'(wd));
        end else if (p) exp_d = ref_rd(a);
        else exp_if = ref_rd(a);
        check("if_rdata", 32'(if_rdata), 32'(exp_if));
        check("d_rdata", 32'(d_rdata), 32'(exp_d));
        last_d = p;
        @(posedge clk); @(negedge clk);
        check("ack_pulse_end", {30'h0, if_ack, d_ack}, 0);
        check("idle_bus", {13'h0, ram_en, ram_oe, ram_we, ram_data}, {13'h0, 3'b111, 16'hFFFF});
    endtask

    task automatic check_reset_state(input string tag);
        check(tag, {ram_en, ram_oe, ram_we, if_ack, d_ack, ram_addr, 9'h0}, {3'b111, 2'b00, 18'h0, 9'h0});
        check("reset_bus_hiz", 32'(ram_data), 32'hFFFF);
        check("reset_rdata", {if_rdata, d_rdata}, 0);
        exp_if = '0; exp_d = '0; last_d = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bit p;
        int mode;
        logic [17:0] ia, da, a;
        logic [15:0] dw;
        logic dwe;
        for (int i = 0; i < 262144; i++) mem[i] = init_val(18'(i));
        mem[18'h10] = 16'h4E21;
        ref_mem[18'h10] = 16'h4E21;
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; if_addr = 18'h00123; d_addr = 18'h00456;
        repeat (2) @(negedge clk);
        check_reset_state("reset_state");
        check("reset_fast", {q_en, q_oe, q_we, q_ack}, 4'b1110);
        rst_n = 1'b1;
        // both requests held from reset: data, fetch, data, fetch
        for (int i = 0; i < 4; i++) begin
            p = !last_d;
            check("rr_order", 32'(p), 32'(i % 2 == 0));
            observe(p, 1'b0, p ? 18'h00456 : 18'h00123, 16'h0, 1'b1);
        end
        if_req = 1'b0; d_req = 1'b0;
        if_req = 1'b1; if_addr = 18'h00010;
        observe(1'b0, 1'b0, 18'h00010, 16'h0, 1'b0);
        check("fetch_4e21", 32'(if_rdata), 32'h4E21);
        d_req = 1'b1; d_we = 1'b1; d_addr = 18'h0BF00; d_wdata = 16'h00FF;
        observe(1'b1, 1'b1, 18'h0BF00, 16'h00FF, 1'b0);
        check("write_00ff", 32'(mem[18'h0BF00]), 32'h00FF);
        repeat (150) begin
            mode = int'($urandom_range(0, 3));
            if_addr = 18'($urandom); d_addr = 18'($urandom);
            d_wdata = 16'($urandom_range(0, 16'hFFFE));
            d_we = (mode == 2) || (mode == 3 && $urandom_range(0, 1) == 1);
            ia = if_addr; da = d_addr; dw = d_wdata; dwe = d_we;
            if_req = (mode == 0 || mode == 3);
            d_req = (mode != 0);
            if (mode == 3) begin
                if (!last_d) begin
                    observe(1'b1, dwe, da, dw, 1'b0);
                    observe(1'b0, 1'b0, ia, 16'h0, 1'b0);
                end else begin
                    observe(1'b0, 1'b0, ia, 16'h0, 1'b0);
                    observe(1'b1, dwe, da, dw, 1'b0);
                end
            end else if (mode == 0) observe(1'b0, 1'b0, ia, 16'h0, 1'b0);
            else observe(1'b1, dwe, da, dw, 1'b0);
        end
        // reset during the write pulse
        d_req = 1'b1; d_we = 1'b1; d_addr = 18'h3FFFF; d_wdata = 16'h1234;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        check("pulse_before_reset", {31'h0, ram_we}, 0);
        #2 rst_n = 1'b0;
        #1 check_reset_state("async_reset");
        d_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("no_ack_in_reset", {30'h0, if_ack, d_ack}, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("no_ack_after_reset", {30'h0, if_ack, d_ack}, 0);
        d_req = 1'b1; d_we = 1'b1; d_addr = 18'h3FFFF; d_wdata = 16'hBEEF;
        observe(1'b1, 1'b1, 18'h3FFFF, 16'hBEEF, 1'b0);
        d_req = 1'b1; d_we = 1'b0; d_addr = 18'h3FFFF;
        observe(1'b1, 1'b0, 18'h3FFFF, 16'h0, 1'b0);
        check("readback_beef", 32'(d_rdata), 32'hBEEF);
        // zero wait states: one RD cycle, ack one edge after grant, address latched
        repeat (4) begin
            a = 18'($urandom);
            q_req = 1'b1; q_addr = a;
            @(posedge clk); @(negedge clk);
            check("fast_rd_strobes", {29'h0, q_en, q_oe, q_we}, 3'b001);
            check("fast_addr", 32'(q_raddr), 32'(a));
            q_addr = ~a;
            @(posedge clk); @(negedge clk);
            check("fast_ack", 32'(q_ack), 1);
            check("fast_rdata", 32'(q_rdata), 32'(a[15:0] ^ 16'h1357));
            check("fast_addr_held", 32'(q_raddr), 32'(a));
            q_req = 1'b0;
            @(posedge clk); @(negedge clk);
            check("fast_ack_end", 32'(q_ack), 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 1, meaning the extra cycles the SRAM strobe (OE or WE) is held low; legal range 0-7.
REQ-002 The block SHALL have port CLK  input  1  single clock; every register updates on its rising edge.
REQ-003 The block SHALL have port RST  input  1  reset; asynchronous and active-low.
REQ-004 The block SHALL have port if_req  input  1  fetch-port read request; held high until if_ack.
REQ-005 The block SHALL have port if_addr  input  18  fetch-port word address.
REQ-006 The block SHALL have port if_rdata  output  16  fetch-port read data.
REQ-007 The block SHALL have port if_ack  output  1  one-cycle completion pulse for the fetch port.
REQ-008 The block SHALL have port d_req  input  1  data-port request; held high until d_ack.
REQ-009 The block SHALL have port d_we  input  1  data-port direction: 1 = write, 0 = read.
REQ-010 The block SHALL have ports d_addr  input  18, d_wdata  input  16 and d_rdata  output  16, giving the data-port address, write data and read data.
REQ-011 The block SHALL have port d_ack  output  1  one-cycle completion pulse for the data port.
REQ-012 The block SHALL have ports ramEN, ramOE and ramWE  output  1 each; all three are active-low SRAM strobes.
REQ-013 The block SHALL have ports ramAddr  output  18 and ramData  inout  16 for the SRAM address and data bus.

Function
REQ-014 The FSM SHALL have states IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD and ACK.
REQ-015 All strobes, ramAddr, the ramData drive-enable, the rdata registers and the acks SHALL be registered, with no combinational path from req to any output.
REQ-016 A request SHALL be granted only in IDLE.
- On a grant, the address, d_we and d_wdata are latched.
- Later changes to these inputs are ignored until ACK.
REQ-017 Arbitration when both requests are high in IDLE SHALL be round-robin.
- The port not granted last wins.
- The last-grant flag resets to "fetch", so data wins the first conflict.
REQ-018 When only one request is high, that port SHALL be granted regardless of the last-grant flag.
REQ-019 Read, timed from the IDLE edge that grants:
- RD holds ramEN=0, ramOE=0, ramWE=1 and ramAddr=latched address for WAIT_CYCLES+1 cycles.
- At the last RD edge, ramData is captured into the granted port's rdata register and the FSM enters ACK.
- The ack rises WAIT_CYCLES+1 edges after the grant (2 at default).
REQ-020 A fetch-port grant SHALL always perform a read.
REQ-021 Write sequence:
- WR_SETUP lasts 1 cycle: ramEN=0, ramOE=1, ramWE=1, data driven.
- WR_PULSE lasts WAIT_CYCLES+1 cycles with ramWE=0.
- WR_HOLD lasts 1 cycle with ramWE=1 and data still driven.
- Then ACK; d_ack rises WAIT_CYCLES+3 edges after the grant (4 at default).
REQ-022 ramData SHALL be driven only in WR_SETUP, WR_PULSE and WR_HOLD, and SHALL be high-Z in all other states.
REQ-023 ramOE and ramWE SHALL never be low simultaneously.
REQ-024 ACK SHALL last exactly one cycle, assert only the granted port's ack, and always return to IDLE.
- No grant occurs in ACK, so a requester that drops req after its ack is never granted twice.
REQ-025 if_rdata and d_rdata SHALL hold their value until the next read on the same port.
REQ-026 A request deasserted mid-transaction SHALL NOT abort it; the sequence completes and the ack still pulses.
REQ-027 In IDLE, outputs SHALL be ramEN=1, ramOE=1, ramWE=1, ramAddr holding its last value and ramData high-Z.
REQ-028 The wait counter SHALL be 3 bits and reload on every state entry; when WAIT_CYCLES=0, RD and WR_PULSE each last 1 cycle.

Reset
REQ-029 RST low SHALL asynchronously force, mid-transaction included:
- FSM to IDLE, ramEN/ramOE/ramWE=1, ramAddr=0, ramData high-Z;
- if_rdata=d_rdata=0, if_ack=d_ack=0;
- last-grant flag to "fetch" and counter to 0.
REQ-030 Any in-flight transaction SHALL be discarded by reset with no ack issued; requesters must re-request after RST is released.

Verification
REQ-031 Fetch read: if_req, if_addr=0x00010, SRAM model returns 0x4E21 -> ramOE low for 2 cycles; if_ack pulses 2 edges after grant; if_rdata=0x4E21.
REQ-032 Data write: d_req, d_we=1, d_addr=0x0BF00, d_wdata=0x00FF -> ramWE low for exactly 2 cycles inside a driven window of 4; model holds 0x00FF at 0x0BF00; d_ack pulses 4 edges after grant; ramOE stays 1 throughout.
REQ-033 Contention: both requests held high continuously from reset -> grant order data, fetch, data, fetch; each ack exactly one cycle; no double grant.
REQ-034 Reset mid-write: RST pulled low during WR_PULSE -> ramWE=1 and ramData high-Z immediately; no d_ack; after release a fresh write completes normally.
REQ-035 Address stability: if_addr changed during RD -> ramAddr keeps the latched address; with WAIT_CYCLES=0 the read acks 1 edge after grant.
REQ-036 Bus check: over all cycles in REQ-031 to REQ-035, ramData is driven only in write states and ramOE and ramWE are never both 0.
